// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_core
// Description : Stopwatch timing engine. Counts elapsed 10 ns ticks under
//               start/stop, lap and clear pulses and drives the value and
//               decimal-point mask for the seven-segment display driver.
// Options     : STOPWATCH_LAP_EN - compiles in the lap register and LAP state.
//               When undefined, the lap input is ignored, lap_active is 0 and
//               display_time always follows elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_core #(
    parameter logic [38:0] MAX_COUNT    = 39'h7F_FFFF_FFFF,
    parameter int unsigned BLINK_CYCLES = 50_000_000,
    parameter logic [7:0]  DP_PATTERN   = 8'b0010_1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [38:0] display_time,
    output logic [38:0] elapsed,
    output logic [7:0]  dec_points,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    // Blink counter only has to reach BLINK_CYCLES-1; keep at least one bit.
    localparam int unsigned          C_BLINK_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [C_BLINK_W-1:0] C_BLINK_LAST = C_BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2,
        ST_STOPPED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [38:0]          elapsed_q, elapsed_d;
    logic                 overflow_q, overflow_d;
    logic [C_BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q, blink_on_d;
    logic                 count_en;

`ifdef STOPWATCH_LAP_EN
    logic [38:0]          lap_q, lap_d;
`else
    // The lap pulse has no function in this build; the port is kept so the
    // pin-out does not depend on the configuration.
    logic                 unused_lap;
    assign unused_lap = lap;
`endif

    // Next-state decode; clear beats start_stop beats lap in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!clear && start_stop) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start_stop) begin
                    state_d = ST_STOPPED;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap) begin
                    state_d = ST_LAP;
                end
`endif
            end
            ST_LAP: begin
`ifdef STOPWATCH_LAP_EN
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start_stop) begin
                    state_d = ST_STOPPED;
                end else if (lap) begin
                    state_d = ST_RUNNING;
                end
`else
                // Unreachable without the lap feature; recover to IDLE.
                state_d = ST_IDLE;
`endif
            end
            ST_STOPPED: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start_stop) begin
                    state_d = ST_RUNNING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Elapsed counter with saturation and sticky overflow flag.
    always_comb begin
        count_en   = ((state_q == ST_RUNNING) || (state_q == ST_LAP)) &&
                     !clear && !start_stop && (elapsed_q < MAX_COUNT);
        elapsed_d  = elapsed_q;
        overflow_d = overflow_q;
        if (clear) begin
            elapsed_d  = 39'd0;
            overflow_d = 1'b0;
        end else begin
            if (count_en) begin
                elapsed_d = elapsed_q + 39'd1;
            end
            // Flag is raised on the edge the counter arrives at the limit.
            if (elapsed_d == MAX_COUNT) begin
                overflow_d = 1'b1;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap register captures the pre-edge count when a lap is taken from RUNNING.
    always_comb begin
        lap_d = lap_q;
        if (clear) begin
            lap_d = 39'd0;
        end else if ((state_q == ST_RUNNING) && !start_stop && lap) begin
            lap_d = elapsed_q;
        end
    end
`endif

    // Blink timer: restarts lit on every STOPPED entry, toggles every BLINK_CYCLES.
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if ((state_q == ST_STOPPED) && (state_d == ST_STOPPED)) begin
            if (blink_cnt_q == C_BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_on_d  = blink_on_q;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            elapsed_q   <= 39'd0;
            overflow_q  <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            elapsed_q   <= elapsed_d;
            overflow_q  <= overflow_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap register storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            lap_q <= 39'd0;
        end else begin
            lap_q <= lap_d;
        end
    end
`endif

    // Decimal points: steady while counting, blinking while stopped, dark in IDLE.
    always_comb begin
        dec_points = 8'h00;
        case (state_q)
            ST_RUNNING, ST_LAP: dec_points = DP_PATTERN;
            ST_STOPPED:         dec_points = blink_on_q ? DP_PATTERN : 8'h00;
            default:            dec_points = 8'h00;
        endcase
    end

    assign elapsed  = elapsed_q;
    assign overflow = overflow_q;
    assign running  = (state_q == ST_RUNNING) || (state_q == ST_LAP);

`ifdef STOPWATCH_LAP_EN
    assign lap_active   = (state_q == ST_LAP);
    assign display_time = (state_q == ST_LAP) ? lap_q : elapsed_q;
`else
    assign lap_active   = 1'b0;
    assign display_time = elapsed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_core
// Description : Scoreboard bench for stopwatch_core. Two instances share the
//               command inputs: u_dut (full-range counter) and u_sat
//               (MAX_COUNT = 100); both blink with a 4-cycle half-period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif
    localparam logic [7:0] DP = 8'b0010_1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [38:0] disp_a, elap_a, disp_b, elap_b;
    logic [7:0]  dp_a, dp_b;
    logic        run_a, lapa_a, ovf_a, run_b, lapa_b, ovf_b;

    typedef struct {
        string       name;
        logic [38:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [38:0] ob[$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    stopwatch_core #(.BLINK_CYCLES(4)) u_dut (
        .clock(clock), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
        .display_time(disp_a), .elapsed(elap_a), .dec_points(dp_a),
        .running(run_a), .lap_active(lapa_a), .overflow(ovf_a)
    );

    stopwatch_core #(.MAX_COUNT(39'd100), .BLINK_CYCLES(4)) u_sat (
        .clock(clock), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
        .display_time(disp_b), .elapsed(elap_b), .dec_points(dp_b),
        .running(run_b), .lap_active(lapa_b), .overflow(ovf_b)
    );

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One-cycle command pulse sampled at the next rising edge.
    task automatic pulse(input logic ss, input logic lp, input logic cl);
        start_stop = ss; lap = lp; clear = cl;
        step(1);
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e; logic [38:0] o;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        sb.push_back('{"rst elapsed", 39'd0});    ob.push_back(elap_a);
        sb.push_back('{"rst display", 39'd0});    ob.push_back(disp_a);
        sb.push_back('{"rst dec_points", 39'd0}); ob.push_back(39'(dp_a));
        sb.push_back('{"rst running", 39'd0});    ob.push_back(39'(run_a));
        sb.push_back('{"rst lap_active", 39'd0}); ob.push_back(39'(lapa_a));
        sb.push_back('{"rst overflow", 39'd0});   ob.push_back(39'(ovf_a));
        sb.push_back('{"rst sat elapsed", 39'd0}); ob.push_back(elap_b);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = ob.pop_front(); checks++;
            if (o !== e.exp) begin failures++; $display("FAIL %s: observed %0d expected %0d", e.name, o, e.exp); end
        end
    endtask

    task automatic test_run_stop();
        exp_t e; logic [38:0] o;
        step(6);
        pulse(1'b1, 1'b0, 1'b0);
        sb.push_back('{"run dp while running", 39'(DP)});
        step(999);
        ob.push_back(39'(dp_a));
        sb.push_back('{"stop elapsed", 39'd999});
        sb.push_back('{"stop running", 39'd0});
        sb.push_back('{"stop dp lit on entry", 39'(DP)});
        pulse(1'b1, 1'b0, 1'b0);
        ob.push_back(elap_a); ob.push_back(39'(run_a)); ob.push_back(39'(dp_a));
        sb.push_back('{"hold elapsed", 39'd999});
        sb.push_back('{"hold dp k=500", 39'd0});
        sb.push_back('{"sat elapsed held", 39'd100});
        sb.push_back('{"sat overflow", 39'd1});
        sb.push_back('{"sat running", 39'd0});
        step(500);
        ob.push_back(elap_a); ob.push_back(39'(dp_a));
        ob.push_back(elap_b); ob.push_back(39'(ovf_b)); ob.push_back(39'(run_b));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = ob.pop_front(); checks++;
            if (o !== e.exp) begin failures++; $display("FAIL %s: observed %0d expected %0d", e.name, o, e.exp); end
        end
    endtask

    task automatic test_blink();
        exp_t e; logic [38:0] o;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        step(5);
        for (int k = 0; k < 12; k++) begin
            sb.push_back('{$sformatf("blink k=%0d", k), (((k / 4) % 2) == 0) ? 39'(DP) : 39'd0});
        end
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            ob.push_back(39'(dp_a));
            step(1);
        end
        for (int k = 0; k < 6; k++) begin
            sb.push_back('{$sformatf("restart dp j=%0d", k), 39'(DP)});
        end
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            ob.push_back(39'(dp_a));
            step(1);
        end
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = ob.pop_front(); checks++;
            if (o !== e.exp) begin failures++; $display("FAIL %s: observed %0d expected %0d", e.name, o, e.exp); end
        end
    endtask

    task automatic test_lap();
        exp_t e; logic [38:0] o;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        step(200);
        sb.push_back('{"lap1 display", LAP_EN ? 39'd200 : 39'd201});
        sb.push_back('{"lap1 lap_active", 39'(LAP_EN)});
        sb.push_back('{"lap1 elapsed", 39'd201});
        sb.push_back('{"lap1 running", 39'd1});
        sb.push_back('{"lap1 dp", 39'(DP)});
        pulse(1'b0, 1'b1, 1'b0);
        ob.push_back(disp_a); ob.push_back(39'(lapa_a)); ob.push_back(elap_a);
        ob.push_back(39'(run_a)); ob.push_back(39'(dp_a));
        sb.push_back('{"lap frozen display", LAP_EN ? 39'd200 : 39'd500});
        sb.push_back('{"lap live elapsed", 39'd500});
        step(299);
        ob.push_back(disp_a); ob.push_back(elap_a);
        sb.push_back('{"lap2 display", 39'd501});
        sb.push_back('{"lap2 lap_active", 39'd0});
        sb.push_back('{"lap2 running", 39'd1});
        pulse(1'b0, 1'b1, 1'b0);
        ob.push_back(disp_a); ob.push_back(39'(lapa_a)); ob.push_back(39'(run_a));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = ob.pop_front(); checks++;
            if (o !== e.exp) begin failures++; $display("FAIL %s: observed %0d expected %0d", e.name, o, e.exp); end
        end
    endtask

    task automatic test_priority();
        exp_t e; logic [38:0] o;
        sb.push_back('{"clr+ss elapsed", 39'd0});
        sb.push_back('{"clr+ss running", 39'd0});
        sb.push_back('{"clr+ss display", 39'd0});
        sb.push_back('{"clr+ss dp", 39'd0});
        pulse(1'b1, 1'b0, 1'b1);
        ob.push_back(elap_a); ob.push_back(39'(run_a)); ob.push_back(disp_a); ob.push_back(39'(dp_a));
        sb.push_back('{"clr+ss stays idle elapsed", 39'd0});
        sb.push_back('{"clr+ss stays idle running", 39'd0});
        step(3);
        ob.push_back(elap_a); ob.push_back(39'(run_a));
        pulse(1'b1, 1'b0, 1'b0);
        step(10);
        sb.push_back('{"ss+lap elapsed", 39'd10});
        sb.push_back('{"ss+lap running", 39'd0});
        sb.push_back('{"ss+lap lap_active", 39'd0});
        sb.push_back('{"ss+lap display", 39'd10});
        sb.push_back('{"ss+lap dp", 39'(DP)});
        pulse(1'b1, 1'b1, 1'b0);
        ob.push_back(elap_a); ob.push_back(39'(run_a)); ob.push_back(39'(lapa_a));
        ob.push_back(disp_a); ob.push_back(39'(dp_a));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = ob.pop_front(); checks++;
            if (o !== e.exp) begin failures++; $display("FAIL %s: observed %0d expected %0d", e.name, o, e.exp); end
        end
    endtask

    task automatic test_overflow();
        exp_t e; logic [38:0] o;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        sb.push_back('{"sat elapsed 99", 39'd99});
        sb.push_back('{"sat overflow below max", 39'd0});
        step(99);
        ob.push_back(elap_b); ob.push_back(39'(ovf_b));
        sb.push_back('{"sat elapsed at max", 39'd100});
        sb.push_back('{"sat overflow at max", 39'd1});
        step(1);
        ob.push_back(elap_b); ob.push_back(39'(ovf_b));
        sb.push_back('{"sat elapsed hold", 39'd100});
        sb.push_back('{"sat overflow sticky", 39'd1});
        sb.push_back('{"sat still running", 39'd1});
        sb.push_back('{"full elapsed 150", 39'd150});
        sb.push_back('{"full overflow", 39'd0});
        step(50);
        ob.push_back(elap_b); ob.push_back(39'(ovf_b)); ob.push_back(39'(run_b));
        ob.push_back(elap_a); ob.push_back(39'(ovf_a));
        sb.push_back('{"sat clear overflow", 39'd0});
        sb.push_back('{"sat clear elapsed", 39'd0});
        pulse(1'b0, 1'b0, 1'b1);
        ob.push_back(39'(ovf_b)); ob.push_back(elap_b);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = ob.pop_front(); checks++;
            if (o !== e.exp) begin failures++; $display("FAIL %s: observed %0d expected %0d", e.name, o, e.exp); end
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e; logic [38:0] o;
        pulse(1'b1, 1'b0, 1'b0);
        sb.push_back('{"midrun elapsed 57", 39'd57});
        step(57);
        ob.push_back(elap_a);
        sb.push_back('{"mrst elapsed", 39'd0});
        sb.push_back('{"mrst display", 39'd0});
        sb.push_back('{"mrst dp", 39'd0});
        sb.push_back('{"mrst running", 39'd0});
        sb.push_back('{"mrst lap_active", 39'd0});
        sb.push_back('{"mrst overflow", 39'd0});
        reset = 1'b1; lap = 1'b1;
        step(1);
        reset = 1'b0; lap = 1'b0;
        ob.push_back(elap_a); ob.push_back(disp_a); ob.push_back(39'(dp_a));
        ob.push_back(39'(run_a)); ob.push_back(39'(lapa_a)); ob.push_back(39'(ovf_a));
        sb.push_back('{"mrst idle elapsed", 39'd0});
        sb.push_back('{"mrst idle running", 39'd0});
        step(3);
        ob.push_back(elap_a); ob.push_back(39'(run_a));
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = ob.pop_front(); checks++;
            if (o !== e.exp) begin failures++; $display("FAIL %s: observed %0d expected %0d", e.name, o, e.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_blink();
        test_lap();
        test_priority();
        test_overflow();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
